stage2_adder: RTL
=================

Name: stage2_adder

Overview:
- Downstream consumer of the first adder-tree stage.
- Takes the four registered partial sums, adds them pairwise (stage 2), then adds the two results (stage 3), and presents the final sum of all eight original operands.
- Two registered pipeline stages with valid/ready flow control, per-result overflow tracking, and a delivered-result counter.
- Sits between the first-stage adder registers and the result consumer in the pipelined adder top level.

Parameters:
- WIDTH, 8, bit width of partial sums and final sum (matches first-stage output width).
- CNT_W, 16, width of delivered-result counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  s0_reg..s3_reg hold a valid set this cycle
- in_ready  output  1  block accepts the input set this cycle
- s0_reg  input  WIDTH  partial sum 0 (in0+in1)
- s1_reg  input  WIDTH  partial sum 1 (in2+in3)
- s2_reg  input  WIDTH  partial sum 2 (in4+in5)
- s3_reg  input  WIDTH  partial sum 3 (in6+in7)
- in_ovf  input  1  upstream overflow flag for this set (tie 0 if unused)
- out_sum  output  WIDTH  final sum, modulo 2^WIDTH
- out_ovf  output  1  any carry-out lost anywhere in this result's tree
- out_valid  output  1  out_sum/out_ovf valid
- out_ready  input  1  consumer accepts the result this cycle
- result_count  output  CNT_W  number of results delivered

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- Reset: out_valid=0, out_sum=0, out_ovf=0, result_count=0, internal stage-2 valid=0, stage-2 data=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight results; none is delivered and the counter does not increment.
- Stage 2 registers:
  - p0 = s0_reg+s1_reg and p1 = s2_reg+s3_reg, each truncated to WIDTH.
  - ovf2 = carry(p0) | carry(p1) | in_ovf.
  - v2 = stage-2 valid bit.
- Stage 3 (output) registers:
  - out_sum = p0+p1, truncated to WIDTH.
  - out_ovf = ovf2 | carry(p0+p1).
- Flow control:
  - adv3 = !out_valid | out_ready.
  - in_ready = !v2 | adv3 (combinational, no dependence on in_valid).
  - Input accepted iff in_valid & in_ready.
  - Stage 2 loads when in_ready; v2 takes the value of (in_valid & in_ready) on each load. When in_ready=0, stage 2 holds.
  - Stage 3 loads when adv3; out_valid takes v2 on each load. When adv3=0, outputs hold.
- Hold guarantee: while out_valid=1 and out_ready=0, out_sum, out_ovf and out_valid are stable.
- Latency: an accepted set appears on out_valid exactly 2 cycles later when no stall occurs.
- Throughput: 1 set/cycle with out_ready held high. No bubbles are inserted and no results are dropped or duplicated.
- Capacity: 2 results. With out_ready=0, at most 2 sets are accepted before in_ready falls.
- Counter: result_count increments by 1 on each cycle where out_valid & out_ready. It wraps from 2^CNT_W-1 to 0.
- Simultaneous load and drain: the output drains and stage 2 advances in the same cycle, and a new input is accepted that same cycle.
- in_valid=0 cycles propagate as bubbles (valid=0). Data registers may load in bubble cycles; their contents are don't-care while the associated valid is 0.

Test Plan:
- Basic sum: reset, then one set s0..s3 = 3,5,7,9 with out_ready=1 -> out_valid=1 two cycles later, out_sum=24, out_ovf=0, result_count=1.
- Streaming: 10 back-to-back sets, set k = k,k,k,k, out_ready=1 -> results 0,4,8,...,36 on consecutive cycles starting at cycle 2; in_ready is never 0; result_count=10.
- Overflow and wrap (WIDTH=8):
  - s0..s3 = 200,100,0,0 -> out_sum=44, out_ovf=1.
  - s0..s3 = 128,0,128,0 -> out_sum=0, out_ovf=1.
  - s0..s3 = 0,0,0,0 with in_ovf=1 -> out_sum=0, out_ovf=1.
- Backpressure: out_ready=0, drive 4 sets (1,1,1,1), (2,2,2,2), (3,3,3,3), (4,4,4,4) -> only the first two are accepted, in_ready=0 afterwards, out_sum=4 holds stable. Then raise out_ready -> outputs 4, 8, then the third and fourth sets are accepted and produce 12, 16, in order, with no loss.
- Reset mid-stream: 2 sets in flight, assert rst for 1 cycle -> out_valid=0, result_count=0, in_ready=1 next cycle; the in-flight sums never appear.
- Counter wrap (CNT_W=4): deliver 17 results -> result_count reads 1.

Source files
------------

// File: rtl/stage2_adder.sv
// stage2_adder: second and third levels of the pipelined adder tree.
// Folds four registered partial sums into one result behind a two-deep valid/ready pipeline.
module stage2_adder #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] s0_reg,
   input  logic [WIDTH-1:0] s1_reg,
   input  logic [WIDTH-1:0] s2_reg,
   input  logic [WIDTH-1:0] s3_reg,
   input  logic             in_ovf,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] result_count
);

   // Unsigned add that keeps the carry-out in the top bit.
   function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   logic [WIDTH-1:0] sum_a_p2_q, sum_a_p2_d;
   logic [WIDTH-1:0] sum_b_p2_q, sum_b_p2_d;
   logic             ovf_p2_q,   ovf_p2_d;
   logic             vld_p2_q,   vld_p2_d;

   logic [WIDTH-1:0] sum_p3_q, sum_p3_d;
   logic             ovf_p3_q, ovf_p3_d;
   logic             vld_p3_q, vld_p3_d;

   logic [CNT_W-1:0] count_q, count_d;

   logic             adv3;
   logic             in_ready_w;
   logic [WIDTH:0]   full_a;
   logic [WIDTH:0]   full_b;
   logic [WIDTH:0]   full_ab;

   always_comb begin
      adv3       = !vld_p3_q || out_ready;
      in_ready_w = !vld_p2_q || adv3;

      full_a  = add_carry(s0_reg, s1_reg);
      full_b  = add_carry(s2_reg, s3_reg);
      full_ab = add_carry(sum_a_p2_q, sum_b_p2_q);

      // Stage 2: pairwise sums; a stalled output with a full stage 2 freezes it.
      sum_a_p2_d = sum_a_p2_q;
      sum_b_p2_d = sum_b_p2_q;
      ovf_p2_d   = ovf_p2_q;
      vld_p2_d   = vld_p2_q;
      if (in_ready_w) begin
         sum_a_p2_d = full_a[WIDTH-1:0];
         sum_b_p2_d = full_b[WIDTH-1:0];
         ovf_p2_d   = full_a[WIDTH] | full_b[WIDTH] | in_ovf;
         vld_p2_d   = in_valid;
      end

      // Stage 3: final sum, held while the consumer stalls a valid result.
      sum_p3_d = sum_p3_q;
      ovf_p3_d = ovf_p3_q;
      vld_p3_d = vld_p3_q;
      if (adv3) begin
         sum_p3_d = full_ab[WIDTH-1:0];
         ovf_p3_d = ovf_p2_q | full_ab[WIDTH];
         vld_p3_d = vld_p2_q;
      end

      count_d = count_q;
      if (vld_p3_q && out_ready) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_a_p2_q <= '0;
         sum_b_p2_q <= '0;
         ovf_p2_q   <= 1'b0;
         vld_p2_q   <= 1'b0;
         sum_p3_q   <= '0;
         ovf_p3_q   <= 1'b0;
         vld_p3_q   <= 1'b0;
         count_q    <= '0;
      end else begin
         sum_a_p2_q <= sum_a_p2_d;
         sum_b_p2_q <= sum_b_p2_d;
         ovf_p2_q   <= ovf_p2_d;
         vld_p2_q   <= vld_p2_d;
         sum_p3_q   <= sum_p3_d;
         ovf_p3_q   <= ovf_p3_d;
         vld_p3_q   <= vld_p3_d;
         count_q    <= count_d;
      end
   end

   assign in_ready     = in_ready_w;
   assign out_sum      = sum_p3_q;
   assign out_ovf      = ovf_p3_q;
   assign out_valid    = vld_p3_q;
   assign result_count = count_q;

endmodule
